// File: rtl/nx_fifo_rd_unpack.sv
// Pops wide words from a show-ahead FIFO and emits them as narrow valid/ready
// slices, holding one word in flight plus one prefetched word.
module nx_fifo_rd_unpack #(
    parameter int IN_WIDTH      = 64,
    parameter int OUT_WIDTH     = 16,
    parameter int RATIO         = 4,
    parameter bit LSB_FIRST     = 1'b1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     fifo_empty,
    input  logic [IN_WIDTH-1:0]      fifo_rdata,
    input  logic                     fifo_rerr,
    output logic                     fifo_ren,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_WIDTH-1:0]     out_data,
    output logic                     out_last,
    output logic                     out_err,
    output logic [ERR_CNT_WIDTH-1:0] err_words
);

    localparam int               IDX_W    = $clog2(RATIO);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

    if (RATIO < 2) begin : g_bad_ratio
        $error("nx_fifo_rd_unpack: RATIO must be >= 2");
    end
    if (IN_WIDTH != RATIO * OUT_WIDTH) begin : g_bad_width
        $error("nx_fifo_rd_unpack: IN_WIDTH must equal RATIO*OUT_WIDTH");
    end

    logic                     run_q;
    logic                     cur_vld_q,  cur_vld_d;
    logic [IN_WIDTH-1:0]      cur_word_q, cur_word_d;
    logic                     cur_err_q,  cur_err_d;
    logic [IDX_W-1:0]         idx_q,      idx_d;
    logic                     nxt_vld_q,  nxt_vld_d;
    logic [IN_WIDTH-1:0]      nxt_word_q, nxt_word_d;
    logic                     nxt_err_q,  nxt_err_d;
    logic [ERR_CNT_WIDTH-1:0] err_words_q, err_words_d;

    logic acc;
    logic release_cur;
    logic cur_free;

    // Slice table in emission order, so out_data is a plain index by idx_q.
    logic [OUT_WIDTH-1:0] slices [RATIO];
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
        if (LSB_FIRST) begin : g_lsb
            assign slices[i] = cur_word_q[i*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_msb
            assign slices[i] = cur_word_q[(RATIO-1-i)*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Pop depends only on registers, fifo_empty and clear -- never on out_ready.
    assign fifo_ren    = run_q & ~fifo_empty & ~nxt_vld_q & ~clear;
    assign out_valid   = cur_vld_q & ~clear;
    assign out_data    = slices[idx_q];
    assign out_last    = (idx_q == IDX_LAST);
    assign out_err     = cur_err_q;
    assign err_words   = err_words_q;

    assign acc         = out_valid & out_ready;
    assign release_cur = acc & (idx_q == IDX_LAST);
    assign cur_free    = ~cur_vld_q | release_cur;

    always_comb begin
        // NOTE: every _d is given its hold value first, so no branch can infer a latch.
        cur_vld_d   = cur_vld_q;
        cur_word_d  = cur_word_q;
        cur_err_d   = cur_err_q;
        idx_d       = idx_q;
        nxt_vld_d   = nxt_vld_q;
        nxt_word_d  = nxt_word_q;
        nxt_err_d   = nxt_err_q;
        err_words_d = err_words_q;

        if (clear) begin
            cur_vld_d = 1'b0;
            nxt_vld_d = 1'b0;
            idx_d     = '0;
        end else begin
            if (acc) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end

            if (cur_free) begin
                if (nxt_vld_q) begin
                    cur_vld_d  = 1'b1;
                    cur_word_d = nxt_word_q;
                    cur_err_d  = nxt_err_q;
                    nxt_vld_d  = 1'b0;
                end else if (fifo_ren) begin
                    cur_vld_d  = 1'b1;
                    cur_word_d = fifo_rdata;
                    cur_err_d  = fifo_rerr;
                end else begin
                    cur_vld_d  = 1'b0;
                end
            end

            // A pop lands in the prefetch slot unless it went straight into cur.
            if (fifo_ren && (!cur_free || nxt_vld_q)) begin
                nxt_vld_d  = 1'b1;
                nxt_word_d = fifo_rdata;
                nxt_err_d  = fifo_rerr;
            end
        end

        if (fifo_ren && fifo_rerr && (err_words_q != '1)) begin
            err_words_d = err_words_q + 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q       <= 1'b0;
            cur_vld_q   <= 1'b0;
            // NOTE: the word holders are plain flops, not a RAM, so they take the reset too.
            cur_word_q  <= '0;
            cur_err_q   <= 1'b0;
            idx_q       <= '0;
            nxt_vld_q   <= 1'b0;
            nxt_word_q  <= '0;
            nxt_err_q   <= 1'b0;
            err_words_q <= '0;
        end else begin
            run_q       <= 1'b1;
            cur_vld_q   <= cur_vld_d;
            cur_word_q  <= cur_word_d;
            cur_err_q   <= cur_err_d;
            idx_q       <= idx_d;
            nxt_vld_q   <= nxt_vld_d;
            nxt_word_q  <= nxt_word_d;
            nxt_err_q   <= nxt_err_d;
            err_words_q <= err_words_d;
        end
    end

endmodule

// File: tb/tb_nx_fifo_rd_unpack.sv
// Scoreboard bench: two unpackers (LSB-first/16-bit counter and MSB-first/2-bit
// counter) fed the same word stream from small show-ahead FIFO models.
module tb_nx_fifo_rd_unpack;

    localparam int IW = 64;
    localparam int OW = 16;
    localparam int R  = 4;

    typedef struct packed { logic [IW-1:0] data; logic err; } word_t;
    typedef struct packed { logic [OW-1:0] data; logic last; logic err; } slice_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clear     = 1'b0;
    logic out_ready = 1'b0;
    always #5 clk = ~clk;

    logic          fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [IW-1:0] fifo_rdata0 = '0,   fifo_rdata1 = '0;
    logic          fifo_rerr0  = 1'b0, fifo_rerr1  = 1'b0;
    logic          fifo_ren0, fifo_ren1;
    logic          out_valid0, out_valid1;
    logic [OW-1:0] out_data0, out_data1;
    logic          out_last0, out_last1;
    logic          out_err0, out_err1;
    logic [15:0]   err_words0;
    logic [1:0]    err_words1;

    nx_fifo_rd_unpack #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .RATIO(R), .LSB_FIRST(1'b1), .ERR_CNT_WIDTH(16)
    ) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_empty(fifo_empty0), .fifo_rdata(fifo_rdata0), .fifo_rerr(fifo_rerr0),
        .fifo_ren(fifo_ren0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_last(out_last0), .out_err(out_err0),
        .err_words(err_words0)
    );

    nx_fifo_rd_unpack #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .RATIO(R), .LSB_FIRST(1'b0), .ERR_CNT_WIDTH(2)
    ) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_empty(fifo_empty1), .fifo_rdata(fifo_rdata1), .fifo_rerr(fifo_rerr1),
        .fifo_ren(fifo_ren1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_last(out_last1), .out_err(out_err1),
        .err_words(err_words1)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    word_t  feed[$];
    word_t  fq0[$], fq1[$];
    slice_t exp0[$], exp1[$];
    int     err_pushed = 0;
    int     popped0 = 0, done0 = 0, n_acc0 = 0, max_ahead = 0;
    logic   ren0_s = 1'b0, ren1_s = 1'b0;

    // Pop requests are sampled mid-cycle and applied at the next rising edge.
    always @(negedge clk) begin
        ren0_s = rst_n && fifo_ren0;
        ren1_s = rst_n && fifo_ren1;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq0.delete();
            fq1.delete();
            fifo_empty0 <= 1'b1;
            fifo_empty1 <= 1'b1;
        end else begin
            if (ren0_s) begin
                if (fq0.size() == 0) check("pop_on_empty0", 1, 0);
                else void'(fq0.pop_front());
            end
            if (ren1_s) begin
                if (fq1.size() == 0) check("pop_on_empty1", 1, 0);
                else void'(fq1.pop_front());
            end
            while (feed.size() != 0) begin
                fq0.push_back(feed[0]);
                fq1.push_back(feed[0]);
                void'(feed.pop_front());
            end
            fifo_empty0 <= (fq0.size() == 0);
            fifo_empty1 <= (fq1.size() == 0);
            fifo_rdata0 <= (fq0.size() != 0) ? fq0[0].data : '0;
            fifo_rerr0  <= (fq0.size() != 0) ? fq0[0].err  : 1'b0;
            fifo_rdata1 <= (fq1.size() != 0) ? fq1[0].data : '0;
            fifo_rerr1  <= (fq1.size() != 0) ? fq1[0].err  : 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_ren0) popped0++;
            if (out_valid0) begin
                if (exp0.size() == 0) check("extra_slice0", 1, 0);
                else begin
                    check("data0", out_data0, exp0[0].data);
                    check("last0", out_last0, exp0[0].last);
                    check("err0",  out_err0,  exp0[0].err);
                    if (out_ready) begin
                        if (exp0[0].last) done0++;
                        n_acc0++;
                        void'(exp0.pop_front());
                    end
                end
            end
            if (popped0 - done0 > max_ahead) max_ahead = popped0 - done0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid1) begin
            if (exp1.size() == 0) check("extra_slice1", 1, 0);
            else begin
                check("data1", out_data1, exp1[0].data);
                check("last1", out_last1, exp1[0].last);
                check("err1",  out_err1,  exp1[0].err);
                if (out_ready) void'(exp1.pop_front());
            end
        end
    end

    task automatic push_word(input logic [IW-1:0] d, input logic e);
        word_t w;
        w.data = d;
        w.err  = e;
        feed.push_back(w);
        for (int i = 0; i < R; i++) begin
            slice_t s0;
            slice_t s1;
            s0.data = d[i*OW +: OW];
            s0.last = (i == R-1);
            s0.err  = e;
            s1.data = d[(R-1-i)*OW +: OW];
            s1.last = (i == R-1);
            s1.err  = e;
            exp0.push_back(s0);
            exp1.push_back(s1);
        end
        if (e) err_pushed++;
    endtask

    function automatic bit idle();
        return exp0.size() == 0 && exp1.size() == 0 && feed.size() == 0 &&
               fq0.size() == 0 && fq1.size() == 0;
    endfunction

    function automatic logic [63:0] exp_ew(input int sat);
        return (err_pushed > sat) ? 64'(sat) : 64'(err_pushed);
    endfunction

    task automatic drain(input string tag);
        int c = 0;
        while (!idle() && c < 600) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, 64'(c < 600), 1);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int base;
        int vc;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid0", out_valid0, 0);
        check("rst_ren0",   fifo_ren0,  0);
        check("rst_last0",  out_last0,  0);
        check("rst_err0",   out_err0,   0);
        check("rst_ew0",    err_words0, 0);
        check("rst_valid1", out_valid1, 0);
        check("rst_ew1",    err_words1, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Single word: pop in cycle t, first slice in t+1
        push_word(64'h4444_3333_2222_1111, 1'b0);
        @(negedge clk);
        check("idle_ren", fifo_ren0, 0);
        @(negedge clk);
        check("lat_ren",   fifo_ren0,  1);
        check("lat_valid", out_valid0, 0);
        @(negedge clk);
        check("lat_valid_t1", out_valid0, 1);
        check("lat_ren_t1",   fifo_ren0,  0);
        drain("drain_single");
        check("single_pops", popped0, 1);

        // Eight back-to-back words: 32 slices with no bubble
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom}, 1'b0);
        for (int c = 0; c < 50 && !out_valid0; c++) @(negedge clk);
        vc = 0;
        for (int c = 0; c < 32; c++) begin
            if (out_valid0) vc++;
            @(negedge clk);
        end
        check("no_bubble", vc, 32);
        drain("drain_burst");

        // Backpressure pattern 1,0,0,1
        max_ahead = 0;
        for (int i = 0; i < 8; i++) push_word({$urandom, $urandom}, 1'b0);
        for (int c = 0; c < 500 && !idle(); c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain("drain_bp");
        check("max_ahead_le2", 64'(max_ahead <= 2), 1);
        check("bp_pops_done", popped0 - done0, 0);

        // Error flags and saturating count
        push_word(64'h0101_0202_0303_0404, 1'b0);
        push_word(64'hdead_beef_cafe_f00d, 1'b1);
        push_word(64'h1234_5678_9abc_def0, 1'b0);
        drain("drain_err");
        check("ew0_one", err_words0, exp_ew(65535));
        check("ew1_one", err_words1, exp_ew(3));
        for (int i = 0; i < 5; i++) push_word({$urandom, $urandom}, 1'b1);
        drain("drain_err5");
        check("ew0_six", err_words0, exp_ew(65535));
        check("ew1_sat", err_words1, exp_ew(3));

        // Clear after two slices with the next word prefetched
        base = n_acc0;
        push_word(64'haaaa_bbbb_cccc_dddd, 1'b0);
        push_word(64'h5555_6666_7777_8888, 1'b0);
        for (int c = 0; c < 50 && n_acc0 < base + 2; c++) begin @(posedge clk); #1; end
        check("clr_prefetch0", fq0.size(), 0);
        check("clr_prefetch1", fq1.size(), 0);
        clear = 1'b1;
        exp0.delete();
        exp1.delete();
        push_word(64'h0f0f_1e1e_2d2d_3c3c, 1'b0);
        @(negedge clk);
        check("clr_valid0", out_valid0, 0);
        check("clr_valid1", out_valid1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("clr_hold_ren",   fifo_ren0,  0);
        check("clr_hold_valid", out_valid0, 0);
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("post_clr_ren",   fifo_ren0,  1);
        check("post_clr_valid", out_valid0, 0);
        drain("drain_clr");
        check("clr_ew0", err_words0, exp_ew(65535));
        check("clr_ew1", err_words1, exp_ew(3));

        // Reset in the middle of a word
        base = n_acc0;
        push_word(64'h9999_8888_7777_6666, 1'b1);
        for (int c = 0; c < 50 && n_acc0 < base + 1; c++) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp0.delete();
        exp1.delete();
        feed.delete();
        err_pushed = 0;
        @(negedge clk);
        check("mid_rst_valid", out_valid0, 0);
        check("mid_rst_ren",   fifo_ren0,  0);
        check("mid_rst_ew0",   err_words0, 0);
        check("mid_rst_ew1",   err_words1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_word(64'h1357_2468_abcd_ef01, 1'b1);
        drain("drain_after_rst");
        check("after_rst_ew0", err_words0, exp_ew(65535));
        check("after_rst_ew1", err_words1, exp_ew(3));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/nx_fifo_rd_unpack.md
Name: nx_fifo_rd_unpack

Overview:
- Downstream consumer of the RAM-backed 1R1W FIFO.
- Pops wide words from the FIFO's show-ahead read port and emits them as narrow slices on a valid/ready stream.
- Holds one word being unpacked plus one prefetched word, so that fifo_ren has no combinational dependence on out_ready.
- Tags each slice with the word's uncorrectable-read-error flag and keeps a saturating count of errored words.

Parameters:
- IN_WIDTH, 64, FIFO word width; must equal RATIO*OUT_WIDTH.
- OUT_WIDTH, 16, output slice width.
- RATIO, 4, slices per word; must be >= 2 (elaboration error otherwise).
- LSB_FIRST, 1, 1 = slice 0 is bits [OUT_WIDTH-1:0]; 0 = most-significant slice first.
- ERR_CNT_WIDTH, 16, width of the errored-word counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of internal state
- fifo_empty  input  1  FIFO empty
- fifo_rdata  input  IN_WIDTH  FIFO head word; valid in any cycle where fifo_empty=0
- fifo_rerr  input  1  uncorrectable error on the head word; qualified like fifo_rdata
- fifo_ren  output  1  pop FIFO head this cycle
- out_valid  output  1  slice valid
- out_ready  input  1  sink accepts slice
- out_data  output  OUT_WIDTH  current slice
- out_last  output  1  slice is slice RATIO-1 of its word
- out_err  output  1  word carrying this slice had fifo_rerr=1
- err_words  output  ERR_CNT_WIDTH  saturating count of errored words popped

Behaviour:
- State registers:
  - cur_vld, cur_word, cur_err, idx[log2(RATIO)]
  - nxt_vld, nxt_word, nxt_err
  - run: 0 in reset, 1 from the first clock edge after rst_n deasserts
  - err_words
- Reset values: all of the above 0. Outputs during reset: out_valid=0, fifo_ren=0, out_last=0, out_err=0, err_words=0. out_data is don't-care.
- fifo_ren = run & !fifo_empty & !nxt_vld & !clear. Depends only on registers, fifo_empty and clear.
- out_valid = cur_vld & !clear.
- out_data = slice idx of cur_word, ordered per LSB_FIRST.
- out_last = (idx==RATIO-1). out_err = cur_err.
- Accept: acc = out_valid & out_ready.
  - If idx<RATIO-1: idx++.
  - If idx==RATIO-1: idx<=0 and cur is released.
- Refill of cur when cur is empty or released this cycle, in priority order:
  1. nxt_vld: cur<=nxt, nxt_vld<=0.
  2. Else if fifo_ren: cur<=fifo_rdata/fifo_rerr.
  3. Else cur_vld<=0.
- Pop data goes to nxt when cur stays occupied, or when cur is refilled from nxt in the same cycle.
- The FIFO is show-ahead, so data is sampled in the same cycle fifo_ren=1.
- Latency: FIFO goes non-empty at cycle t with internal state empty gives fifo_ren at t and out_valid at t+1.
- Throughput: one slice per cycle, sustained while the FIFO is non-empty and out_ready=1. Because RATIO >= 2, the prefetch always refills before cur drains. No bubble between words.
- err_words increments by 1 on each pop with fifo_rerr=1. It saturates at all-ones and is not cleared by clear.
- clear:
  - Highest priority.
  - Next cycle: cur_vld=0, nxt_vld=0, idx=0.
  - No pop occurs in the clear cycle; out_valid=0, so no handshake happens.
  - Asserting clear for multiple cycles holds the block empty.
- Backpressure: with out_ready=0, out_data, out_last and out_err are stable while out_valid=1. At most one further word is prefetched, then fifo_ren=0.
- Reset mid-word: all state is dropped asynchronously and no slice is emitted during reset. A partially consumed word is lost; the FIFO side is reset by the same rst_n.
- Unsupported: fifo_empty=0 during reset. Nothing is popped until run=1.

Test Plan:
- Reset, then one word 64'h4444_3333_2222_1111 (RATIO=4, LSB_FIRST=1), out_ready=1 -> fifo_ren for 1 cycle; slices 1111, 2222, 3333, 4444 on consecutive cycles from t+1; out_last only on 4444.
- 8 back-to-back words, out_ready=1 -> 32 consecutive valid slices with no bubble; fifo_ren never asserted while nxt_vld=1.
- Same stream with out_ready toggling 1,0,0,1 -> each slice held stable while stalled; no loss or duplication; at most 2 words popped ahead of the sink.
- Second word popped with fifo_rerr=1 -> out_err=1 on all 4 of its slices only; err_words=1. With ERR_CNT_WIDTH=2, five errored words -> err_words=3.
- clear asserted after slice 2 of a word, with the next word prefetched -> out_valid=0 next cycle; both words dropped; next FIFO word emitted from slice 0; err_words unchanged.
- LSB_FIRST=0 with the same word -> slices 4444, 3333, 2222, 1111, with out_last on 1111.
